// File: rtl/iter_div_sqrt_mvp.sv
// Iterative radix-2 mantissa divider / square-rooter, one result bit per cycle.
// Ports: Clk_CI/Rst_SI; Div/Sqrt/Kill controls; operands Mant/Exp/Sign a,b;
// format selects; Ready_SO, Done_SO, Mant_res_DO (57b), Exp_res_DO, Sign_res_DO.
module iter_div_sqrt_mvp #(
  parameter int C_MANT_FP64 = 52,
  parameter int C_EXP_FP64  = 11
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_SI,
  input  logic                         Div_start_SI,
  input  logic                         Sqrt_start_SI,
  input  logic                         Kill_SI,
  input  logic [C_MANT_FP64:0]         Mant_a_DI,
  input  logic [C_MANT_FP64:0]         Mant_b_DI,
  input  logic signed [C_EXP_FP64+1:0] Exp_a_DI,
  input  logic signed [C_EXP_FP64+1:0] Exp_b_DI,
  input  logic                         Sign_a_DI,
  input  logic                         Sign_b_DI,
  input  logic                         FP32_SI,
  input  logic                         FP64_SI,
  input  logic                         FP16_SI,
  input  logic                         FP16ALT_SI,
  output logic                         Ready_SO,
  output logic                         Done_SO,
  output logic [C_MANT_FP64+4:0]       Mant_res_DO,
  output logic signed [C_EXP_FP64+1:0] Exp_res_DO,
  output logic                         Sign_res_DO
);

  localparam int MW = C_MANT_FP64 + 1;
  localparam int RW = C_MANT_FP64 + 5;
  localparam int EW = C_EXP_FP64 + 2;
  localparam int SW = RW + 3;
  localparam int CW = 6;
  localparam int SH = RW - 1 - C_MANT_FP64;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0]        rem_q;
  logic [RW-1:0]        quot_q;
  logic [RW-1:0]        mask_q;
  logic [CW-1:0]        cnt_q;
  logic [MW-1:0]        mb_q;
  logic                 sqrt_q;
  logic signed [EW-1:0] exp_q;
  logic                 sign_q;

  logic                 start_acc;
  logic                 last;
  logic                 is_sqrt;

  logic signed [EW-1:0] bias;
  logic [CW-1:0]        iter_m1;
  logic signed [EW-1:0] sq_e;
  logic signed [EW-1:0] exp_start;
  logic [SW-1:0]        rem_start;

  logic [SW-1:0]        trial;
  logic                 ge;
  logic [SW-1:0]        diff;
  logic [SW-1:0]        rem_next;
  logic [RW-1:0]        quot_next;
  logic [RW-1:0]        res_final;

  always_comb begin
    bias    = EW'(127);
    iter_m1 = CW'(23);
    unique case (1'b1)
      FP64_SI: begin
        bias    = EW'(1023);
        iter_m1 = CW'(56);
      end
      FP32_SI: begin
        bias    = EW'(127);
        iter_m1 = CW'(29);
      end
      FP16_SI: begin
        bias    = EW'(15);
        iter_m1 = CW'(23);
      end
      FP16ALT_SI: begin
        bias    = EW'(127);
        iter_m1 = CW'(23);
      end
      default: begin
        bias    = EW'(127);
        iter_m1 = CW'(23);
      end
    endcase
  end

  assign is_sqrt = ~Div_start_SI;
  assign sq_e    = Exp_a_DI - bias;

  // Odd sqrt exponent: radicand doubled so the halved exponent is exact.
  always_comb begin
    exp_start = Exp_a_DI - Exp_b_DI + bias;
    rem_start = SW'(Mant_a_DI);
    if (is_sqrt) begin
      exp_start = (sq_e >>> 1) + bias;
      if (sq_e[0])
        rem_start = SW'(Mant_a_DI) << (SH + 1);
      else
        rem_start = SW'(Mant_a_DI) << SH;
    end
  end

  // Sqrt remainder is scaled by 2^k, so the trial term is 2Q + 2^-k.
  always_comb begin
    if (sqrt_q)
      trial = SW'({quot_q, 1'b0}) + SW'(mask_q);
    else
      trial = SW'(mb_q);
    ge        = rem_q >= trial;
    diff      = ge ? rem_q - trial : rem_q;
    rem_next  = diff << 1;
    quot_next = ge ? (quot_q | mask_q) : quot_q;
    res_final = quot_next | ((|diff) ? mask_q : '0);
  end

  always_comb begin
    state_d   = state_q;
    Ready_SO  = 1'b0;
    Done_SO   = 1'b0;
    start_acc = 1'b0;
    last      = 1'b0;
    unique case (state_q)
      IDLE: begin
        Ready_SO = ~Rst_SI;
        if (!Kill_SI && (Div_start_SI || Sqrt_start_SI)) begin
          start_acc = 1'b1;
          state_d   = ITER;
        end
      end
      ITER: begin
        if (Kill_SI) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        Ready_SO = ~Rst_SI;
        Done_SO  = ~Rst_SI;
        if (Kill_SI) begin
          state_d = IDLE;
        end else if (Div_start_SI || Sqrt_start_SI) begin
          start_acc = 1'b1;
          state_d   = ITER;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quot_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      mb_q        <= '0;
      sqrt_q      <= 1'b0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      Mant_res_DO <= '0;
      Exp_res_DO  <= '0;
      Sign_res_DO <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        rem_q  <= rem_start;
        quot_q <= '0;
        mask_q <= {1'b1, {(RW-1){1'b0}}};
        cnt_q  <= iter_m1;
        mb_q   <= Mant_b_DI;
        sqrt_q <= is_sqrt;
        exp_q  <= exp_start;
        sign_q <= is_sqrt ? Sign_a_DI : (Sign_a_DI ^ Sign_b_DI);
      end else if (state_q == ITER && !Kill_SI) begin
        rem_q  <= rem_next;
        quot_q <= quot_next;
        mask_q <= mask_q >> 1;
        cnt_q  <= cnt_q - 1'b1;
        if (last) begin
          Mant_res_DO <= res_final;
          Exp_res_DO  <= exp_q;
          Sign_res_DO <= sign_q;
        end
      end
    end
  end

endmodule
